// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one uart_tx among N_REQ requesters
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [N_REQ-1:0]                          req_i,
  input  logic [8*N_REQ-1:0]                        req_data_i,
  input  logic [N_REQ-1:0]                          req_last_i,
  output logic [N_REQ-1:0]                          req_ack_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_o,
  output logic                                      grant_valid_o,
  output logic                                      frame_done_o,
  output logic                                      timeout_err_o,
  output logic                                      start_trig_o,
  output logic [7:0]                                tx_data_o,
  input  logic                                      tx_busy_i,
  input  logic                                      tx_done_i
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_END, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [GW-1:0]    sel;
  logic [GW:0]      sum;
  logic             sel_found;
  logic [GW-1:0]    grant_inc;
  logic             last_q, last_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [CW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             gv_q, gv_d;
  logic             fd_q, fd_d;
  logic             to_q, to_d;
  logic             st_q, st_d;
  logic [7:0]       data_q, data_d;
  logic             wdog_exp;
  logic             gap_end;

  assign wdog_exp  = (wdog_q == WW'(TIMEOUT_CYC - 1));
  assign gap_end   = (gap_q == CW'(GAP_CYC - 1));
  assign grant_inc = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin pick: first requesting index at or above rr_q, wrapping past N_REQ-1
  always_comb begin
    sel       = rr_q;
    sel_found = 1'b0;
    sum       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      if (req_i[sum[GW-1:0]]) begin
        sel       = sum[GW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // State and all registered outputs; every output clears on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      last_q  <= 1'b0;
      wdog_q  <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      gv_q    <= 1'b0;
      fd_q    <= 1'b0;
      to_q    <= 1'b0;
      st_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      gv_q    <= gv_d;
      fd_q    <= fd_d;
      to_q    <= to_d;
      st_q    <= st_d;
      data_q  <= data_d;
    end
  end

  // Next state: frame-level ownership, tx_done takes priority over watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!tx_busy_i && sel_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done_i) state_d = (last_q || !req_i[grant_q]) ? S_END : S_ISSUE;
        else if (wdog_exp) state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      end
      S_END:   state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs appear the cycle after the deciding state
  always_comb begin
    grant_d = grant_q;
    rr_d    = rr_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    data_d  = data_q;
    ack_d   = '0;
    st_d    = 1'b0;
    fd_d    = 1'b0;
    to_d    = to_q;
    gv_d    = (state_d == S_ISSUE) || (state_d == S_WAIT);
    case (state_q)
      S_IDLE: if (state_d == S_ISSUE) grant_d = sel;
      S_ISSUE: begin
        st_d           = 1'b1;
        ack_d[grant_q] = 1'b1;
        data_d         = req_data_i[{grant_q, 3'b000} +: 8];
        last_d         = req_last_i[grant_q];
        wdog_d         = '0;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (!tx_done_i && wdog_exp) begin
          to_d  = 1'b1;
          rr_d  = grant_inc;
          gap_d = '0;
        end
      end
      S_END: begin
        fd_d  = 1'b1;
        rr_d  = grant_inc;
        gap_d = '0;
      end
      S_GAP:   gap_d = gap_q + 1'b1;
      default: ;
    endcase
  end

  assign req_ack_o     = ack_q;
  assign grant_o       = grant_q;
  assign grant_valid_o = gv_q;
  assign frame_done_o  = fd_q;
  assign timeout_err_o = to_q;
  assign start_trig_o  = st_q;
  assign tx_data_o     = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with uart_tx stub
module tb_uart_tx_arbiter;
  localparam int GAP  = 4;
  localparam int TMO  = 50;
  localparam int BYTE = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [1:0]  grant;
  logic        grant_valid, frame_done, timeout_err, start_trig;
  logic [7:0]  tx_data;
  logic        tx_busy, tx_done;

  int n_chk = 0, n_pass = 0;
  int n_ack = 0, n_fd = 0;
  int cyc = 0, st_cyc = 0, fd_cyc = 0;
  bit fd_seen = 0, gap_chk = 0, stall = 0;
  int bcnt = 0;
  int base_ack, base_fd, budget;

  logic [8:0] q0[$], q1[$], q2[$], q3[$];
  logic [9:0] exp_q[$];

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data), .req_last_i(req_last),
    .req_ack_o(req_ack), .grant_o(grant), .grant_valid_o(grant_valid),
    .frame_done_o(frame_done), .timeout_err_o(timeout_err), .start_trig_o(start_trig),
    .tx_data_o(tx_data), .tx_busy_i(tx_busy), .tx_done_i(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic present(input logic [1:0] i);
    logic [8:0] h;
    bit has;
    h = '0;
    case (i)
      2'd0: begin has = q0.size() > 0; if (has) h = q0[0]; end
      2'd1: begin has = q1.size() > 0; if (has) h = q1[0]; end
      2'd2: begin has = q2.size() > 0; if (has) h = q2[0]; end
      default: begin has = q3.size() > 0; if (has) h = q3[0]; end
    endcase
    req[i] = has;
    req_data[{i, 3'b000} +: 8] = h[7:0];
    req_last[i] = h[8];
  endtask

  task automatic pop(input logic [1:0] i);
    case (i)
      2'd0: void'(q0.pop_front());
      2'd1: void'(q1.pop_front());
      2'd2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic push_byte(input logic [1:0] i, input logic [7:0] d, input logic last);
    case (i)
      2'd0: q0.push_back({last, d});
      2'd1: q1.push_back({last, d});
      2'd2: q2.push_back({last, d});
      default: q3.push_back({last, d});
    endcase
    if (!req[i]) present(i);
  endtask

  task automatic expect_byte(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic clr();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    exp_q.delete();
    req = '0; req_data = '0; req_last = '0;
    fd_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int lim);
    int b;
    b = lim;
    while (n_fd < target && b > 0) begin @(negedge clk); b--; end
    chk("wait_frame_done", n_fd, target);
  endtask

  task automatic wait_ack(input int target, input int lim);
    int b;
    b = lim;
    while (n_ack < target && b > 0) begin @(negedge clk); b--; end
    chk("wait_ack", n_ack, target);
  endtask

  // Requester model: on ack, retire the captured byte and present the next or drop req
  initial forever begin
    @(posedge clk); #1;
    if (!rst)
      for (int k = 0; k < 4; k++)
        if (req_ack[k]) begin pop(2'(k)); present(2'(k)); end
  end

  // uart_tx stub: busy for BYTE cycles after start_trig, then tx_done pulse (suppressed when stalled)
  initial begin
    tx_busy = 1'b0; tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tx_busy = 1'b0; tx_done = 1'b0; bcnt = 0;
      end else begin
        tx_done = 1'b0;
        if (start_trig) begin
          chk("trig_while_busy", tx_busy, 0);
          tx_busy = 1'b1;
          bcnt = stall ? 3 : BYTE;
        end else if (tx_busy) begin
          bcnt--;
          if (bcnt == 0) begin tx_busy = 1'b0; tx_done = !stall; end
        end
      end
    end
  end

  // Scoreboard monitor
  initial forever begin
    logic [9:0] e;
    @(posedge clk); #1;
    if (!rst) begin
      if (start_trig === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_trig", tx_data, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("grant", grant, e[9:8]);
          chk("tx_data", tx_data, e[7:0]);
        end
        st_cyc = cyc;
        if (gap_chk && fd_seen) chk("gap_cycles", cyc - fd_cyc, GAP + 2);
        fd_seen = 0;
      end
      if (req_ack != 4'b0) begin
        n_ack++;
        chk("ack_owner", req_ack, 4'b1 << grant);
        chk("ack_with_trig", start_trig, 1);
      end
      if (frame_done) begin
        n_fd++;
        chk("fd_grant_valid", grant_valid, 0);
        fd_cyc = cyc;
        fd_seen = 1;
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk);
    chk("rst_start_trig", start_trig, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // single requester, 3-byte frame
    base_ack = n_ack; base_fd = n_fd;
    expect_byte(0, 8'h55); expect_byte(0, 8'hA3); expect_byte(0, 8'h0F);
    push_byte(0, 8'h55, 0); push_byte(0, 8'hA3, 0); push_byte(0, 8'h0F, 1);
    wait_fd(base_fd + 1, 400);
    repeat (10) @(negedge clk);
    chk("t1_acks", n_ack - base_ack, 3);
    chk("t1_frames", n_fd - base_fd, 1);
    chk("t1_exp_left", exp_q.size(), 0);

    // round robin 0,2,0,2 with gap
    do_reset();
    base_fd = n_fd; gap_chk = 1;
    expect_byte(0, 8'hA0); expect_byte(2, 8'hC0); expect_byte(0, 8'hA1); expect_byte(2, 8'hC1);
    push_byte(0, 8'hA0, 1); push_byte(0, 8'hA1, 1); push_byte(2, 8'hC0, 1); push_byte(2, 8'hC1, 1);
    wait_fd(base_fd + 4, 800);
    gap_chk = 0;
    chk("t2_exp_left", exp_q.size(), 0);

    // frame lock: req1 arrives mid-frame
    do_reset();
    base_ack = n_ack; base_fd = n_fd;
    expect_byte(0, 8'h31); expect_byte(0, 8'h32); expect_byte(0, 8'h33); expect_byte(0, 8'h34);
    expect_byte(1, 8'h22);
    push_byte(0, 8'h31, 0); push_byte(0, 8'h32, 0); push_byte(0, 8'h33, 0); push_byte(0, 8'h34, 1);
    wait_ack(base_ack + 1, 100);
    push_byte(1, 8'h22, 1);
    wait_fd(base_fd + 2, 800);
    chk("t3_exp_left", exp_q.size(), 0);

    // drop mid-frame, then rr pointer must be 2
    do_reset();
    base_fd = n_fd;
    expect_byte(1, 8'h11);
    push_byte(1, 8'h11, 0);
    wait_fd(base_fd + 1, 300);
    chk("t4_grant_valid", grant_valid, 0);
    expect_byte(2, 8'hD2); expect_byte(0, 8'hD0);
    push_byte(0, 8'hD0, 1); push_byte(2, 8'hD2, 1);
    wait_fd(base_fd + 3, 600);
    chk("t4_exp_left", exp_q.size(), 0);

    // watchdog abort, next requester served
    do_reset();
    base_fd = n_fd; stall = 1;
    expect_byte(0, 8'hE1); expect_byte(1, 8'h77);
    push_byte(0, 8'hE1, 1); push_byte(1, 8'h77, 1);
    budget = 300;
    while (!timeout_err && budget > 0) begin @(negedge clk); budget--; end
    chk("t5_timeout_set", timeout_err, 1);
    chk("t5_timeout_cycle", cyc - st_cyc, TMO);
    chk("t5_grant_valid", grant_valid, 0);
    chk("t5_no_frame_done", n_fd - base_fd, 0);
    stall = 0;
    wait_fd(base_fd + 1, 400);
    chk("t5_sticky", timeout_err, 1);
    chk("t5_exp_left", exp_q.size(), 0);

    // reset during byte 2
    base_ack = n_ack;
    expect_byte(0, 8'hB1); expect_byte(0, 8'hB2);
    push_byte(0, 8'hB1, 0); push_byte(0, 8'hB2, 0); push_byte(0, 8'hB3, 1);
    wait_ack(base_ack + 2, 200);
    rst = 1'b1;
    clr();
    @(negedge clk);
    chk("t6_start_trig", start_trig, 0);
    chk("t6_req_ack", req_ack, 0);
    chk("t6_grant", grant, 0);
    chk("t6_grant_valid", grant_valid, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_timeout", timeout_err, 0);
    chk("t6_tx_data", tx_data, 0);
    rst = 1'b0;
    base_fd = n_fd;
    expect_byte(0, 8'h5A);
    push_byte(0, 8'h5A, 1);
    @(negedge clk);
    chk("t6_gv_sel", grant_valid, 1);
    chk("t6_grant_sel", grant, 0);
    chk("t6_trig_early", start_trig, 0);
    @(negedge clk);
    chk("t6_trig", start_trig, 1);
    chk("t6_ack", req_ack, 4'b0001);
    wait_fd(base_fd + 1, 300);
    chk("t6_exp_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
